memory_rx: RTL and testbench
============================

# memory_rx

Receive-side word buffer of the APB–LIN bridge. Accepts bytes from the LIN receiver, packs them little-endian into 32-bit words, and stores them in a 16-entry circular buffer. Complete frames only become visible to the APB side when the frame ends cleanly; aborted or overflowed frames are rolled back. The APB register block pops words one at a time.

## Interface
- DEPTH_LOG2, 4, log2 of buffer depth in 32-bit words (DEPTH = 16)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rx_byte_valid  in  1  one-cycle strobe: rx_byte holds a received data byte
- rx_byte  in  8  received byte
- rx_frame_end  in  1  one-cycle strobe: frame received with good checksum
- rx_frame_err  in  1  one-cycle strobe: frame aborted (checksum, framing, or timeout error)
- RD_en  in  1  pop request from APB side
- ovf_clr  in  1  clears the sticky overflow flag
- RD_data1  out  32  popped word (registered)
- RD_valid  out  1  one-cycle strobe: RD_data1 was updated
- count  out  DEPTH_LOG2+1  committed words available to read
- empty  out  1  count == 0
- full  out  1  speculative occupancy == DEPTH
- overflow  out  1  sticky: a frame was dropped for lack of space
- rx_frame_ok  out  1  one-cycle strobe: a frame was committed

## Operation
- Storage: mem[DEPTH] x 32. Pointers rd_ptr, wr_com (committed), and wr_spec (speculative) are each DEPTH_LOG2+1 bits wide and wrap modulo 2·DEPTH. Occupancy = wr_spec − rd_ptr. count = wr_com − rd_ptr.
- Packer: byte_cnt (0..3) plus a 32-bit staging word. A byte at lane k goes to bits [8k+7:8k]. The first byte of a word lands at [7:0].
- rx_byte_valid:
  - The byte is merged at lane byte_cnt.
  - If byte_cnt == 3: the completed word is written to mem[wr_spec], wr_spec increments, byte_cnt and staging are cleared.
  - If occupancy == DEPTH when a write is needed: no write, drop_frame is set, byte_cnt is still cleared.
- rx_frame_end:
  - If byte_cnt != 0 after merging a same-cycle byte, the partial word is flushed to mem[wr_spec] with upper lanes zero (subject to the same full check).
  - If drop_frame is set: wr_spec returns to wr_com and overflow is set; no rx_frame_ok.
  - Otherwise: wr_com takes the post-write wr_spec, and rx_frame_ok pulses.
  - At most one memory write occurs per cycle. drop_frame and the packer are cleared.
- rx_frame_err: wr_spec returns to wr_com; byte_cnt, staging, and drop_frame are cleared. Takes priority over rx_byte_valid and rx_frame_end in the same cycle, both of which are ignored.
- A frame with no data bytes (end only) commits nothing but still pulses rx_frame_ok.
- RD_en with count != 0: RD_data1 <= mem[rd_ptr], rd_ptr increments. RD_en with count == 0: ignored, RD_data1 holds, RD_valid = 0.
- Read and write in the same cycle are both performed. full and empty are evaluated from start-of-cycle pointers, so a slot freed by a read is usable from the next cycle.
- overflow: set wins over ovf_clr in the same cycle.
- No reads of uncommitted words are possible. A read never passes wr_com.

## Timing
- Reset (sync, high): all pointers, byte_cnt, staging, drop_frame = 0. Outputs: RD_data1 = 0, RD_valid = 0, count = 0, empty = 1, full = 0, overflow = 0, rx_frame_ok = 0. Memory contents are not reset.
- Reset mid-frame discards the partial frame; the first byte after reset goes to lane 0, slot 0.
- Latency: RD_en at edge n → RD_data1/RD_valid valid after edge n+1.
- rx_frame_end at edge n → count, empty, and rx_frame_ok reflect the commit after edge n+1.
- full reflects a speculative write one cycle after the write.
- Strobes may arrive on consecutive cycles. Throughput is one byte per cycle and one pop per cycle.

## Test plan
- Bytes 11,22,33,44,55 then rx_frame_end → count = 2, rx_frame_ok pulse. Two pops return 0x44332211, then 0x00000055, each with RD_valid. Then empty = 1.
- Six bytes then rx_frame_err → count stays 0. Next frame AA,BB,CC,DD + end → one pop returns 0xDDCCBBAA from slot 0.
- Commit 15 one-word frames, then send an 8-byte frame + end → overflow = 1, count = 15, no rx_frame_ok. ovf_clr → overflow = 0. ovf_clr coincident with a new drop → overflow stays 1.
- 40 one-word frames interleaved with pops, pointers wrapping twice → words return in order with no loss. RD_en while empty leaves RD_data1 unchanged.
- Byte 0x77 coincident with rx_frame_end at byte_cnt = 1 → word 0x00007700 | first byte committed. rx_byte_valid + rx_frame_end + rx_frame_err in the same cycle → nothing committed.
- Assert reset after 3 bytes of a frame → all outputs at reset values. A following 4-byte frame commits correctly to slot 0.

Source files
------------

// File: rtl/memory_rx.sv
// Receive-side word buffer: packs LIN bytes little-endian into 32-bit words and
// exposes whole frames to the APB reader only once the frame has ended cleanly.
module memory_rx #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_byte_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_frame_end,
  input  logic                  rx_frame_err,
  input  logic                  RD_en,
  input  logic                  ovf_clr,
  output logic [31:0]           RD_data1,
  output logic                  RD_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  rx_frame_ok
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Handshake: every rx_* input and RD_valid/rx_frame_ok is a single-cycle strobe
  // with no back-pressure; RD_en is a request honoured only when count != 0.
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   wr_com_q, wr_com_d;
  logic [DEPTH_LOG2:0]   wr_spec_q, wr_spec_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           stage_q, stage_d;
  logic                  drop_q, drop_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  frame_ok_q, frame_ok_d;

  logic [DEPTH_LOG2:0]   occupancy;
  logic [DEPTH_LOG2:0]   wr_spec_post;
  logic [31:0]           merged;
  logic                  word_done, partial, need_write, drop_set, ovf_set;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  assign occupancy   = wr_spec_q - rd_ptr_q;
  assign count       = wr_com_q - rd_ptr_q;
  assign empty       = (count == '0);
  assign full        = (occupancy == {1'b1, {DEPTH_LOG2{1'b0}}});
  assign overflow    = overflow_q;
  assign RD_data1    = rd_data_q;
  assign RD_valid    = rd_valid_q;
  assign rx_frame_ok = frame_ok_q;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_com_d     = wr_com_q;
    wr_spec_d    = wr_spec_q;
    byte_cnt_d   = byte_cnt_q;
    stage_d      = stage_q;
    drop_d       = drop_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    frame_ok_d   = 1'b0;
    merged       = stage_q;
    word_done    = 1'b0;
    partial      = 1'b0;
    need_write   = 1'b0;
    drop_set     = 1'b0;
    ovf_set      = 1'b0;
    wr_spec_post = wr_spec_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_spec_q[DEPTH_LOG2-1:0];
    mem_wdata    = '0;

    if (RD_en && (count != '0)) begin
      rd_data_d  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
      rd_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end

    if (rx_frame_err) begin
      wr_spec_d  = wr_com_q;
      byte_cnt_d = '0;
      stage_d    = '0;
      drop_d     = 1'b0;
    end else begin
      if (rx_byte_valid) merged[{byte_cnt_q, 3'b000} +: 8] = rx_byte;
      word_done  = rx_byte_valid && (byte_cnt_q == 2'd3);
      partial    = rx_frame_end && !word_done && ((byte_cnt_q != 2'd0) || rx_byte_valid);
      need_write = word_done || partial;
      // Fullness is judged on start-of-cycle pointers; a same-cycle pop does not help.
      if (need_write) begin
        if (full) begin
          drop_set = 1'b1;
        end else begin
          mem_we       = 1'b1;
          mem_wdata    = merged;
          wr_spec_post = wr_spec_q + 1'b1;
        end
      end
      wr_spec_d = wr_spec_post;
      drop_d    = drop_q | drop_set;
      if (rx_byte_valid) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        stage_d    = word_done ? '0 : merged;
      end
      if (rx_frame_end) begin
        byte_cnt_d = '0;
        stage_d    = '0;
        drop_d     = 1'b0;
        if (drop_q || drop_set) begin
          wr_spec_d = wr_com_q;
          ovf_set   = 1'b1;
        end else begin
          wr_com_d   = wr_spec_post;
          frame_ok_d = 1'b1;
        end
      end
    end

    overflow_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_com_q   <= '0;
      wr_spec_q  <= '0;
      byte_cnt_q <= '0;
      stage_q    <= '0;
      drop_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      frame_ok_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_com_q   <= wr_com_d;
      wr_spec_q  <= wr_spec_d;
      byte_cnt_q <= byte_cnt_d;
      stage_q    <= stage_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      frame_ok_q <= frame_ok_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_memory_rx.sv
// Bench for memory_rx: directed scenarios plus random traffic checked against a
// queue-based model of committed words, pending frame words and partial bytes.
module tb_memory_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_byte_valid, rx_frame_end, rx_frame_err, RD_en, ovf_clr;
  logic [7:0]  rx_byte;
  logic [31:0] RD_data1;
  logic        RD_valid, empty, full, overflow, rx_frame_ok;
  logic [4:0]  count;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic [31:0] spec_q[$];
  logic [7:0]  part_q[$];
  logic        m_drop, m_ovf, m_ok, m_rd_valid;
  logic [31:0] m_rd_data;

  memory_rx #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
    .rx_frame_end(rx_frame_end), .rx_frame_err(rx_frame_err), .RD_en(RD_en),
    .ovf_clr(ovf_clr), .RD_data1(RD_data1), .RD_valid(RD_valid), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .rx_frame_ok(rx_frame_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack_bytes();
    logic [31:0] w = '0;
    foreach (part_q[i]) w[i*8 +: 8] = part_q[i];
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete(); spec_q.delete(); part_q.delete();
    m_drop = 0; m_ovf = 0; m_ok = 0; m_rd_valid = 0; m_rd_data = '0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic e,
                            input logic er, input logic rd, input logic clr);
    bit full0, ovf_set;
    int cnt0;
    full0   = (exp_q.size() + spec_q.size()) == 16;
    cnt0    = exp_q.size();
    ovf_set = 0;
    m_ok    = 0;
    m_rd_valid = 0;
    if (rd && cnt0 != 0) begin
      m_rd_data  = exp_q.pop_front();
      m_rd_valid = 1;
    end
    if (er) begin
      spec_q.delete(); part_q.delete(); m_drop = 0;
    end else begin
      if (v) part_q.push_back(b);
      if (part_q.size() == 4 || (e && part_q.size() > 0)) begin
        if (full0) m_drop = 1;
        else spec_q.push_back(pack_bytes());
        part_q.delete();
      end
      if (e) begin
        if (m_drop) ovf_set = 1;
        else begin
          foreach (spec_q[i]) exp_q.push_back(spec_q[i]);
          m_ok = 1;
        end
        spec_q.delete(); m_drop = 0;
      end
    end
    m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic e,
                      input logic er, input logic rd, input logic clr);
    rx_byte_valid = v; rx_byte = b; rx_frame_end = e;
    rx_frame_err = er; RD_en = rd; ovf_clr = clr;
    model_step(v, b, e, er, rd, clr);
    @(posedge clk); #1;
    rx_byte_valid = 0; rx_frame_end = 0; rx_frame_err = 0; RD_en = 0; ovf_clr = 0;
  endtask

  task automatic do_reset();
    reset = 1; rx_byte_valid = 0; rx_byte = '0; rx_frame_end = 0;
    rx_frame_err = 0; RD_en = 0; ovf_clr = 0;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic send_word_frame(input logic [31:0] w);
    for (int k = 0; k < 4; k++) step(1, w[k*8 +: 8], 0, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (RD_data1 !== 32'h0) begin n_err++; $display("FAIL reset_rd_data: got %h exp 0", RD_data1); end
    n_vec++; if (RD_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b exp 0", RD_valid); end
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", count); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b exp 1", empty); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b exp 0", full); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
    n_vec++; if (rx_frame_ok !== 1'b0) begin n_err++; $display("FAIL reset_frame_ok: got %b exp 0", rx_frame_ok); end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (bytes[i]) step(1, bytes[i], 0, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0);
    n_vec++; if (count !== 5'd2) begin n_err++; $display("FAIL basic_count: got %0d exp 2", count); end
    n_vec++; if (rx_frame_ok !== 1'b1) begin n_err++; $display("FAIL basic_ok: got %b exp 1", rx_frame_ok); end
    step(0, 8'h00, 0, 0, 1, 0);
    n_vec++; if (RD_valid !== 1'b1 || RD_data1 !== 32'h44332211) begin n_err++; $display("FAIL basic_pop0: got %b/%h exp 1/44332211", RD_valid, RD_data1); end
    step(0, 8'h00, 0, 0, 1, 0);
    n_vec++; if (RD_valid !== 1'b1 || RD_data1 !== 32'h00000055) begin n_err++; $display("FAIL basic_pop1: got %b/%h exp 1/00000055", RD_valid, RD_data1); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty: got %b exp 1", empty); end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 6; i++) step(1, 8'($urandom_range(0, 255)), 0, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0);
    n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL abort_count: got %0d exp 0", count); end
    send_word_frame(32'hDDCCBBAA);
    step(0, 8'h00, 0, 0, 1, 0);
    n_vec++; if (RD_valid !== 1'b1 || RD_data1 !== 32'hDDCCBBAA) begin n_err++; $display("FAIL abort_pop: got %b/%h exp 1/ddccbbaa", RD_valid, RD_data1); end
  endtask

  task automatic test_overflow();
    for (int f = 0; f < 15; f++) send_word_frame($urandom);
    n_vec++; if (count !== 5'd15) begin n_err++; $display("FAIL ovf_count15: got %0d exp 15", count); end
    for (int i = 0; i < 8; i++) step(1, 8'($urandom_range(0, 255)), 0, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b exp 1", overflow); end
    n_vec++; if (count !== 5'd15) begin n_err++; $display("FAIL ovf_count: got %0d exp 15", count); end
    n_vec++; if (rx_frame_ok !== 1'b0) begin n_err++; $display("FAIL ovf_no_ok: got %b exp 0", rx_frame_ok); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL ovf_rollback_full: got %b exp 0", full); end
    step(0, 8'h00, 0, 0, 0, 1);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b exp 0", overflow); end
    for (int i = 0; i < 8; i++) step(1, 8'($urandom_range(0, 255)), 0, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0, 1);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b exp 1", overflow); end
    while (exp_q.size() != 0) begin
      step(0, 8'h00, 0, 0, 1, 0);
      n_vec++; if (RD_valid !== 1'b1 || RD_data1 !== m_rd_data) begin n_err++; $display("FAIL ovf_drain: got %b/%h exp 1/%h", RD_valid, RD_data1, m_rd_data); end
    end
    step(0, 8'h00, 0, 0, 0, 1);
  endtask

  task automatic test_wrap();
    int n_pop = 0;
    logic [31:0] held;
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 5; k++) begin
        step(k < 4, 8'($urandom_range(0, 255)), k == 4, 0, k < 2, 0);
        if (m_rd_valid) n_pop++;
        n_vec++; if (RD_valid !== m_rd_valid || RD_data1 !== m_rd_data || count !== 5'(exp_q.size())) begin
          n_err++; $display("FAIL wrap_f%0d: got %b/%h/%0d exp %b/%h/%0d", f, RD_valid, RD_data1, count, m_rd_valid, m_rd_data, exp_q.size());
        end
      end
    end
    while (exp_q.size() != 0) begin
      step(0, 8'h00, 0, 0, 1, 0);
      n_pop++;
      n_vec++; if (RD_valid !== 1'b1 || RD_data1 !== m_rd_data) begin n_err++; $display("FAIL wrap_drain: got %b/%h exp 1/%h", RD_valid, RD_data1, m_rd_data); end
    end
    n_vec++; if (n_pop != 40) begin n_err++; $display("FAIL wrap_pops: got %0d exp 40", n_pop); end
    held = m_rd_data;
    step(0, 8'h00, 0, 0, 1, 0);
    n_vec++; if (RD_valid !== 1'b0 || RD_data1 !== held) begin n_err++; $display("FAIL empty_read: got %b/%h exp 0/%h", RD_valid, RD_data1, held); end
  endtask

  task automatic test_coincident();
    step(1, 8'h12, 0, 0, 0, 0);
    step(1, 8'h77, 1, 0, 0, 0);
    n_vec++; if (rx_frame_ok !== 1'b1 || count !== 5'd1) begin n_err++; $display("FAIL coinc_commit: got %b/%0d exp 1/1", rx_frame_ok, count); end
    step(0, 8'h00, 0, 0, 1, 0);
    n_vec++; if (RD_data1 !== 32'h00007712) begin n_err++; $display("FAIL coinc_word: got %h exp 00007712", RD_data1); end
    step(1, 8'hAB, 1, 1, 0, 0);
    n_vec++; if (rx_frame_ok !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL coinc_err: got %b/%0d exp 0/0", rx_frame_ok, count); end
  endtask

  task automatic test_mid_reset();
    send_word_frame(32'h0BADF00D);
    for (int i = 0; i < 3; i++) step(1, 8'hE0 + 8'(i), 0, 0, 0, 0);
    do_reset();
    n_vec++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL mreset_ptrs: got %0d/%b/%b exp 0/1/0", count, empty, full); end
    n_vec++; if (RD_data1 !== 32'h0 || RD_valid !== 1'b0 || overflow !== 1'b0 || rx_frame_ok !== 1'b0) begin
      n_err++; $display("FAIL mreset_outs: got %h/%b/%b/%b exp 0/0/0/0", RD_data1, RD_valid, overflow, rx_frame_ok);
    end
    send_word_frame(32'h87654321);
    step(0, 8'h00, 0, 0, 1, 0);
    n_vec++; if (RD_valid !== 1'b1 || RD_data1 !== 32'h87654321) begin n_err++; $display("FAIL mreset_frame: got %b/%h exp 1/87654321", RD_valid, RD_data1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)), $urandom_range(0, 11) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
      n_vec++;
      if (RD_valid !== m_rd_valid || RD_data1 !== m_rd_data || count !== 5'(exp_q.size()) ||
          empty !== (exp_q.size() == 0) || full !== ((exp_q.size() + spec_q.size()) == 16) ||
          overflow !== m_ovf || rx_frame_ok !== m_ok) begin
        n_err++;
        $display("FAIL rand_c%0d: got v%b d%h c%0d e%b f%b o%b ok%b exp v%b d%h c%0d o%b ok%b", c,
                 RD_valid, RD_data1, count, empty, full, overflow, rx_frame_ok,
                 m_rd_valid, m_rd_data, exp_q.size(), m_ovf, m_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_overflow();
    test_wrap();
    test_coincident();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
